// File: rtl/mxn_rr_pkg.sv
// mx_pkg: shared definitions for the mxn_rr channel selector.
//   - MX_MODE_SEL / MX_MODE_RR : encodings of the 1-bit mode input
//   - MX_W_DEF / MX_N_DEF / MX_SW_DEF : default data width, channel count,
//     select width
//   - mx_wrap_inc : index + 1 modulo channel count
package mx_pkg;

    localparam int MX_W_DEF  = 8;
    localparam int MX_N_DEF  = 8;
    localparam int MX_SW_DEF = 3;

    typedef enum logic {
        MX_MODE_SEL = 1'b0,
        MX_MODE_RR  = 1'b1
    } mx_mode_e;

    function automatic int mx_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mxn_rr_if.sv
// mxn_rr_if: streaming bus of the mxn_rr channel selector.
//   in_data   N*W  channel i word at [i*W +: W]
//   in_valid  N    channel i has a word
//   in_ready  N    channel i word accepted this cycle
//   mode      1    0 = direct select, 1 = round-robin
//   sel       SW   channel index used in direct-select mode
//   out_data  W    registered selected word
//   out_valid 1    out_data holds a word
//   out_ready 1    consumer accepts out_data
//   out_ch    SW   source channel of out_data (only with MXN_RR_CHAN_EN)
// Modports: slave = the selector, master = producers/consumer side.
interface mxn_rr_if #(
    parameter int W  = mx_pkg::MX_W_DEF,
    parameter int N  = mx_pkg::MX_N_DEF,
    parameter int SW = mx_pkg::MX_SW_DEF
);
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
`ifdef MXN_RR_CHAN_EN
    logic [SW-1:0]  out_ch;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );
`else
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid
    );
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid
    );
`endif
endinterface

// File: rtl/mxn_rr_pick.sv
// rr_pick: combinational rotating priority encoder.
//   req   N   request vector
//   ptr   SW  highest-priority index (must be < N)
//   grant N   one-hot grant, zero when no request
//   idx   SW  index of the granted request
//   found 1   at least one request present
module rr_pick #(
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] idx,
    output logic          found
);

    // Scan ptr..N-1 first, then wrap to 0..ptr-1. The second pass can look
    // at every index because anything >= ptr already failed the first pass.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                idx      = SW'(i);
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                idx      = SW'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mxn_rr.sv
// mxn_rr: N-input, W-bit arbitrated multiplexer with a one-entry output
// register. Each cycle one channel is picked, either by sel (mode 0) or
// round-robin (mode 1), and its word is captured when the output register
// is empty or draining.
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    mxn_rr_if.slave (in_data/in_valid/in_ready, mode, sel,
//          out_data/out_valid/out_ready, out_ch when enabled)
// Optional feature: define MXN_RR_CHAN_EN to add out_ch, the registered
// index of the channel that produced out_data.
module mxn_rr
    import mx_pkg::*;
#(
    parameter int W  = MX_W_DEF,
    parameter int N  = MX_N_DEF,
    parameter int SW = MX_SW_DEF
) (
    input  logic    clk,
    input  logic    reset,
    mxn_rr_if.slave bus
);

    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [SW-1:0] grant_idx;
    logic          found;
    logic          load;
    logic [W-1:0]  sel_word;

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] ptr_q, ptr_d;

    // In direct mode only the selected channel may request; an out-of-range
    // sel matches no channel and so grants nothing.
    always_comb begin
        req = '0;
        if (mx_mode_e'(bus.mode) == MX_MODE_RR) begin
            req = bus.in_valid;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.sel == SW'(i)) begin
                    req[i] = bus.in_valid[i];
                end
            end
        end
    end

    rr_pick #(.N(N), .SW(SW)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .found (found)
    );

    assign load = ~out_valid_q | bus.out_ready;

    // reset gates in_ready directly so nothing is accepted while it is high.
    assign bus.in_ready = grant & {N{load & ~reset}};

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_word = bus.in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ptr_d       = ptr_q;
        if (load) begin
            if (found) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_word;
                ptr_d       = SW'(mx_wrap_inc(int'(grant_idx), N));
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

`ifdef MXN_RR_CHAN_EN
    logic [SW-1:0] out_ch_q, out_ch_d;

    always_comb begin
        out_ch_d = out_ch_q;
        if (load && found) begin
            out_ch_d = grant_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_ch_q <= '0;
        end else begin
            out_ch_q <= out_ch_d;
        end
    end

    assign bus.out_ch = out_ch_q;
`endif

endmodule

// File: tb/tb_mxn_rr.sv
// tb_mxn_rr: randomized and directed stimulus for mxn_rr with a queue-based
// scoreboard. The stimulus process predicts each acceptance from the
// arbitration rules and pushes the expected word; the monitor compares the
// registered output against the queue head and pops on consumption.
module tb_mxn_rr;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int SW = 3;

    typedef struct {
        logic [W-1:0] data;
        int           ch;
    } exp_t;

    logic clk;
    logic reset;

    mxn_rr_if #(.W(W), .N(N), .SW(SW)) bus ();

    mxn_rr #(.W(W), .N(N), .SW(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_vec = 0;
    int   n_err = 0;
    bit   rst_phase = 1'b1;
    exp_t exp_q[$];

    // reference state: is a word held, and which channel has priority next
    bit   m_valid = 1'b0;
    int   m_ptr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] ramp_data();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = W'(8'h10 + i);
        return d;
    endfunction

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
        return d;
    endfunction

    // One clock of stimulus: drive at the falling edge, then predict which
    // channel the next rising edge accepts.
    task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d,
                         input logic md, input logic [SW-1:0] s, input logic ordy);
        int           gi;
        bit           load;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.mode      = md;
        bus.sel       = s;
        bus.out_ready = ordy;
        #2;
        load = !m_valid || ordy;
        gi = -1;
        if (md == 1'b0) begin
            if (int'(s) < N && v[s]) gi = int'(s);
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (gi < 0 && v[j]) gi = j;
            end
        end
        exp_rdy = '0;
        if (load && gi >= 0) exp_rdy[gi] = 1'b1;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (load) begin
            if (gi >= 0) begin
                exp_t e;
                e.data = d[gi*W +: W];
                e.ch   = gi;
                exp_q.push_back(e);
                m_valid = 1'b1;
                m_ptr   = (gi + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
`ifdef MXN_RR_CHAN_EN
        chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
`endif
    endtask

    // Monitor: the head of the queue is the word the register should hold.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_phase) begin
                if (exp_q.size() > 0) begin
                    chk("out_valid", 32'(bus.out_valid), 32'd1);
                    chk("out_data", 32'(bus.out_data), 32'(exp_q[0].data));
`ifdef MXN_RR_CHAN_EN
                    chk("out_ch", 32'(bus.out_ch), 32'(exp_q[0].ch));
`endif
                    if (bus.out_ready) void'(exp_q.pop_front());
                end else begin
                    chk("out_valid_idle", 32'(bus.out_valid), 32'd0);
                end
            end
        end
    end

    initial begin
        logic [N*W-1:0] d;

        reset         = 1'b1;
        bus.in_valid  = '1;
        bus.in_data   = ramp_data();
        bus.mode      = 1'b1;
        bus.sel       = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        reset        = 1'b0;
        bus.in_valid = '0;
        rst_phase    = 1'b0;

        // round-robin over all channels, first grant from channel 0
        for (int k = 0; k < 9; k++) begin
            cycle(8'hFF, ramp_data(), 1'b1, 3'd0, 1'b1);
            chk("rr_all_ready", 32'(bus.in_ready), 32'(1 << (k % 8)));
        end

        // direct select of channel 5 leaves ptr at 6; then 2,5,2
        cycle(8'hFF, ramp_data(), 1'b0, 3'd5, 1'b1);
        chk("sel5_ready", 32'(bus.in_ready), 32'h20);
        cycle(8'h24, ramp_data(), 1'b1, 3'd0, 1'b1);
        chk("rr_wrap_2", 32'(bus.in_ready), 32'h04);
        cycle(8'h24, ramp_data(), 1'b1, 3'd0, 1'b1);
        chk("rr_wrap_5", 32'(bus.in_ready), 32'h20);
        cycle(8'h24, ramp_data(), 1'b1, 3'd0, 1'b1);
        chk("rr_wrap_2b", 32'(bus.in_ready), 32'h04);

        // direct select, then selected channel not valid
        d = ramp_data();
        d[3*W +: W] = 8'hA5;
        cycle(8'hFF, d, 1'b0, 3'd3, 1'b1);
        chk("sel3_ready", 32'(bus.in_ready), 32'h08);
        cycle(8'hF7, d, 1'b0, 3'd3, 1'b1);
        chk("sel3_a5", 32'(bus.out_data), 32'hA5);
        cycle(8'h00, d, 1'b0, 3'd3, 1'b1);
        chk("sel3_drop", 32'(bus.out_valid), 32'd0);

        // backpressure with 0x3C held, then drain and fill on one edge
        d = ramp_data();
        d[1*W +: W] = 8'h3C;
        cycle(8'hFF, d, 1'b0, 3'd1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle(8'hFF, ramp_data(), 1'b0, 3'd2, 1'b0);
            chk("stall_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_data", 32'(bus.out_data), 32'h3C);
        end
        cycle(8'hFF, ramp_data(), 1'b0, 3'd2, 1'b1);
        chk("drain_fill_ready", 32'(bus.in_ready), 32'h04);
        cycle(8'h00, ramp_data(), 1'b0, 3'd2, 1'b1);
        chk("drain_fill_data", 32'(bus.out_data), 32'h12);
        chk("drain_fill_valid", 32'(bus.out_valid), 32'd1);

        for (int k = 0; k < 1500; k++) begin
            cycle(N'($urandom), rand_data(), 1'($urandom), SW'($urandom),
                  ($urandom_range(0, 9) < 7));
        end

        // reset while a word is held under backpressure
        cycle(8'hFF, ramp_data(), 1'b1, 3'd0, 1'b1);
        cycle(8'hFF, ramp_data(), 1'b1, 3'd0, 1'b0);
        @(negedge clk);
        rst_phase = 1'b1;
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs();
        exp_q.delete();
        m_valid = 1'b0;
        m_ptr   = 0;
        @(negedge clk);
        chk("rst_hold_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        reset        = 1'b0;
        bus.in_valid = '0;
        rst_phase    = 1'b0;
        cycle(8'hFF, ramp_data(), 1'b1, 3'd0, 1'b1);
        chk("post_rst_ch0", 32'(bus.in_ready), 32'h01);

        for (int k = 0; k < 300; k++) begin
            cycle(N'($urandom), rand_data(), 1'($urandom), SW'($urandom),
                  ($urandom_range(0, 9) < 5));
        end
        for (int k = 0; k < 3; k++) begin
            cycle(8'h00, ramp_data(), 1'b1, 3'd0, 1'b1);
        end
        @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
